nx_fifo_rd_prefetch: RTL and testbench
======================================

# nx_fifo_rd_prefetch

Read-side prefetch stage placed directly downstream of `nx_fifo_ctrl` and its storage RAM.
- Consumes the controller's `empty`/`rptr` and drives its `ren`/`clear`.
- Issues reads to a 1-cycle-latency RAM and holds returned words in a 3-entry output buffer.
- Presents the words on a valid/ready stream.
- Sustains one word per cycle with no combinational path from `out_ready` to `fifo_ren`.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of RAM word and output data.
- `ADDR_WIDTH`, 2, width of controller read pointer / RAM address.

Ports:
- `clk`  in  1  clock. One clock (`clk`); reset (`rst`) is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `fifo_empty`  in  1  `empty` from `nx_fifo_ctrl`.
- `fifo_rptr`  in  ADDR_WIDTH  `rptr` from `nx_fifo_ctrl`.
- `fifo_ren`  out  1  to `nx_fifo_ctrl` `ren`.
- `fifo_clear`  out  1  to `nx_fifo_ctrl` `clear`.
- `ram_rd_en`  out  1  RAM read enable.
- `ram_rd_addr`  out  ADDR_WIDTH  RAM read address.
- `ram_rd_data`  in  DATA_WIDTH  RAM read data, valid the cycle after `ram_rd_en`.
- `flush`  in  1  discard all buffered and in-flight data and clear the FIFO.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer accepts word.
- `out_data`  out  DATA_WIDTH  output word.
- `buf_count`  out  2  words held in output buffer (0..3).

## Operation
State:
- `count` (0..3): buffered words.
- `inflight` (0/1): read issued last cycle.
- `discard` (0/1): in-flight read must be dropped.
- 3-entry circular buffer with `head`/`tail` indices (mod 3).

Read issue:
- `fifo_ren = !rst && !flush && !fifo_empty && (count + inflight < 3)`.
- `ram_rd_en = fifo_ren`; `ram_rd_addr = fifo_rptr`, combinational passthrough.
- `fifo_ren` never asserts while `fifo_empty=1`, so the controller's `underflow` must never fire.

Data return:
- `inflight` registers `fifo_ren`.
- When `inflight=1` and `discard=0`, write `ram_rd_data` at `tail`, advance `tail`, increment `count`.

Output:
- `out_valid = (count != 0) && !flush`; `out_data = buf[head]`.
- Pop when `out_valid && out_ready`: advance `head`, decrement `count`.
- Push and pop in the same cycle leave `count` unchanged; data order is preserved.
- `count` never exceeds 3; the credit rule guarantees this, and the testbench asserts it.

Flush:
- `fifo_clear = flush`, combinational.
- In the flush cycle: no read is issued and no output transfer occurs.
- Next cycle: `count`, `head` and `tail` are 0.
- `discard` is set for one cycle if `inflight` was 1 in the flush cycle, so the returning word is dropped.
- `flush` held for multiple cycles keeps everything empty.

Reset:
- `count`, `head`, `tail`, `inflight` and `discard` are 0.
- `out_valid=0`, `fifo_ren=0`, `ram_rd_en=0`, `buf_count=0`, `fifo_clear=0` (while `flush=0`).
- `out_data` is don't-care while `out_valid=0`.

## Timing
- Latency: `fifo_empty` falls in cycle T → `fifo_ren`/`ram_rd_en` in T → data captured at end of T+1 → `out_valid=1` in T+2.
- Throughput: with `out_ready=1` continuously and the FIFO never empty, one word per cycle after the initial 2-cycle fill. Steady state is `count=1`, `inflight=1`.
- Backpressure: with `out_ready=0`, at most 3 reads are issued, then `fifo_ren` stays 0. After the consumer pops, the first new read issues the following cycle.
- `fifo_ren` depends only on registered state, `fifo_empty`, `flush` and `rst`. It has no dependence on `out_ready`.
- Reset asserted mid-operation: all state clears at the next edge. A RAM word returning in the cycle after reset is ignored because `inflight` is 0.
- Reset has priority over flush; flush has priority over issue, push and pop.

## Test plan
- **Basic latency:** after reset, write word 0xA5A5_0001 into the FIFO; `fifo_empty` falls at cycle T → `ram_rd_en`=1 at T, `out_valid`=1 with `out_data`=0xA5A5_0001 at T+2, `buf_count`=1.
- **Streaming:** preload 4 words 0x10..0x13, `out_ready`=1 → outputs 0x10,0x11,0x12,0x13 on 4 consecutive cycles; `fifo_ren` is never asserted with `fifo_empty`=1.
- **Backpressure:** preload 4 words, `out_ready`=0 → exactly 3 reads issued, `buf_count`=3, `fifo_empty`=0. Raise `out_ready` → 0x10..0x13 delivered in order with no duplicates or losses.
- **Flush with read in flight:** assert `flush` for one cycle the cycle after a read issues → `fifo_clear`=1 that cycle, `buf_count`=0 next cycle, the returning word is never seen, and the next written word 0x55 is the first one output.
- **Reset mid-stream:** assert `rst` with `buf_count`=2 and a read in flight → next cycle `out_valid`=0, `buf_count`=0, `fifo_ren`=0; normal operation resumes after `rst` deasserts.
- **Push/pop collision:** with `count`=1, a return and a pop in the same cycle → `buf_count` stays 1 and `out_data` advances to the next word.

Source files
------------

// File: rtl/nx_fifo_rd_prefetch.sv
// Read-side prefetch stage between nx_fifo_ctrl/its RAM and a valid/ready consumer.
// Keeps up to three words buffered so one word per cycle streams out without out_ready reaching fifo_ren.
module nx_fifo_rd_prefetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH-1:0] fifo_rptr,
  output logic                  fifo_ren,
  output logic                  fifo_clear,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            buf_count
);

  localparam int DEPTH = 3;

  logic [1:0]            count_reg, count_next;
  logic [1:0]            head_reg, head_next;
  logic [1:0]            tail_reg, tail_next;
  logic                  inflight_reg;
  logic                  discard_reg;
  logic [DATA_WIDTH-1:0] buf_mem [DEPTH];

  logic [2:0]            credit_used;
  logic                  push;
  logic                  pop;

  function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Credit counts buffered words plus the read still returning, so the
  // buffer can never overflow even if the consumer stalls indefinitely.
  assign credit_used = {1'b0, count_reg} + {2'b00, inflight_reg};
  assign fifo_ren    = !rst && !flush && !fifo_empty && (credit_used < 3'd3);
  assign ram_rd_en   = fifo_ren;
  assign ram_rd_addr = fifo_rptr;
  assign fifo_clear  = flush;

  assign out_valid = (count_reg != 2'd0) && !flush;
  assign out_data  = buf_mem[head_reg];
  assign buf_count = count_reg;

  assign push = inflight_reg && !discard_reg && !flush;
  assign pop  = out_valid && out_ready;

  always_comb begin
    count_next = count_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    if (flush) begin
      count_next = 2'd0;
      head_next  = 2'd0;
      tail_next  = 2'd0;
    end else begin
      if (push) tail_next = wrap_inc(tail_reg);
      if (pop)  head_next = wrap_inc(head_reg);
      case ({push, pop})
        2'b10:   count_next = count_reg + 2'd1;
        2'b01:   count_next = count_reg - 2'd1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg    <= 2'd0;
      head_reg     <= 2'd0;
      tail_reg     <= 2'd0;
      inflight_reg <= 1'b0;
      discard_reg  <= 1'b0;
    end else begin
      count_reg    <= count_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      inflight_reg <= fifo_ren;
      discard_reg  <= flush && inflight_reg;
    end
  end

  // Data storage carries no reset; out_data is only meaningful with out_valid.
  always_ff @(posedge clk) begin
    if (push) buf_mem[tail_reg] <= ram_rd_data;
  end

endmodule

// File: tb/tb_nx_fifo_rd_prefetch.sv
// Bench for nx_fifo_rd_prefetch: behavioural FIFO/RAM model, word-order scoreboard and directed scenarios.
`timescale 1ns/1ps
module tb_nx_fifo_rd_prefetch;

  localparam int DW = 32;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [AW-1:0] fifo_rptr;
  logic          fifo_ren;
  logic          fifo_clear;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    buf_count;

  nx_fifo_rd_prefetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rptr(fifo_rptr),
    .fifo_ren(fifo_ren), .fifo_clear(fifo_clear), .ram_rd_en(ram_rd_en),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Behavioural 4-deep FIFO controller + 1-cycle RAM; every accepted write
  // is expected at the output in order unless a flush/reset wipes it.
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] mem [4];
  logic [AW-1:0] wptr, rptr;
  int            cnt;
  logic          wr_fire;
  logic [DW-1:0] exp_q [$];

  assign fifo_empty = (cnt == 0);
  assign fifo_rptr  = rptr;
  assign wr_fire    = wr_en && (cnt < 4) && !rst && !fifo_clear;

  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    if (rst || fifo_clear) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= 0;
      exp_q.delete();
    end else begin
      if (wr_fire) begin
        mem[wptr] <= wr_data;
        wptr      <= wptr + 1'b1;
        exp_q.push_back(wr_data);
      end
      if (fifo_ren) rptr <= rptr + 1'b1;
      cnt <= cnt + int'(wr_fire) - int'(fifo_ren);
    end
  end

  int            xfers = 0;
  logic [DW-1:0] last_out;

  // Monitor: sampled mid-cycle, a valid&&ready here transfers at the next edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      xfers++;
      last_out = out_data;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
      end else begin
        chk("out_order", out_data, exp_q.pop_front());
      end
      $display("xfer %0d data=0x%08h buf_count=%0d", xfers, out_data, buf_count);
    end
    if (buf_count > 2'd3 || (fifo_ren && fifo_empty)) begin
      checks++;
      errors++;
      $display("FAIL invariant: buf_count=%0d fifo_ren=%0b with fifo_empty=%0b", buf_count, fifo_ren, fifo_empty);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    wr_en     = 1'b0;
    repeat (12) tick();
    out_ready = 1'b0;
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int n_valid, cur_run, max_run, n_reads, x0;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; wr_en = 1'b0; wr_data = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_buf_count", buf_count, 0);
    chk("rst_fifo_ren", fifo_ren, 0);
    chk("rst_fifo_clear", fifo_clear, 0);
    tick();
    rst = 1'b0;
    tick();

    // Basic latency: write accepted at the edge starting cycle T
    wr_en = 1'b1; wr_data = 32'hA5A5_0001;
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("lat_rd_en_T", ram_rd_en, 1);
    chk("lat_valid_T", out_valid, 0);
    tick();
    @(negedge clk);
    chk("lat_valid_T1", out_valid, 0);
    tick();
    @(negedge clk);
    chk("lat_valid_T2", out_valid, 1);
    chk("lat_data_T2", out_data, 32'hA5A5_0001);
    chk("lat_count_T2", buf_count, 1);
    tick();
    drain("lat_drain");

    // Streaming: 4 words, consumer always ready
    n_valid = 0; cur_run = 0; max_run = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wr_en   = (i < 4);
      wr_data = 32'h10 + i;
      @(negedge clk);
      if (out_valid) begin n_valid++; cur_run++; end else cur_run = 0;
      if (cur_run > max_run) max_run = cur_run;
      tick();
    end
    chk("stream_total", n_valid, 4);
    chk("stream_consecutive", max_run, 4);
    drain("stream_drain");

    // Backpressure: consumer stalled, only 3 reads may issue
    n_reads = 0;
    for (int i = 0; i < 10; i++) begin
      wr_en   = (i < 4);
      wr_data = 32'h10 + i;
      @(negedge clk);
      if (ram_rd_en) n_reads++;
      tick();
    end
    @(negedge clk);
    chk("bp_reads", n_reads, 3);
    chk("bp_count", buf_count, 3);
    chk("bp_fifo_empty", fifo_empty, 0);
    chk("bp_ren_idle", fifo_ren, 0);
    tick();
    x0 = xfers;
    drain("bp_drain");
    chk("bp_delivered", xfers - x0, 4);

    // Flush the cycle after a read issues
    wr_en = 1'b1; wr_data = 32'h77;
    tick();
    wr_en = 1'b0;
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_clear", fifo_clear, 1);
    chk("flush_valid", out_valid, 0);
    chk("flush_ren", fifo_ren, 0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_count", buf_count, 0);
    n_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      if (out_valid) n_valid++;
    end
    chk("flush_no_stale", n_valid, 0);
    tick();
    wr_en = 1'b1; wr_data = 32'h55;
    tick();
    x0 = xfers;
    drain("flush_drain");
    chk("flush_first_out", last_out, 32'h55);
    chk("flush_one_word", xfers - x0, 1);

    // Reset with two words buffered and one in flight
    wr_en = 1'b1; wr_data = 32'h31;
    tick();
    wr_data = 32'h32;
    tick();
    wr_data = 32'h33;
    tick();
    wr_en = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_count_before", buf_count, 2);
    tick();
    @(negedge clk);
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_count", buf_count, 0);
    chk("rstmid_ren", fifo_ren, 0);
    tick();
    rst = 1'b0;
    n_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      if (out_valid) n_valid++;
    end
    chk("rstmid_no_stale", n_valid, 0);
    tick();
    wr_en = 1'b1; wr_data = 32'h99;
    tick();
    x0 = xfers;
    drain("rstmid_drain");
    chk("rstmid_resume", last_out, 32'h99);

    // Push/pop collision at count=1
    out_ready = 1'b1;
    wr_en = 1'b1; wr_data = 32'hC0;
    tick();
    wr_data = 32'hC1;
    tick();
    wr_data = 32'hC2;
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("coll_count_a", buf_count, 1);
    chk("coll_data_a", out_data, 32'hC0);
    tick();
    @(negedge clk);
    chk("coll_count_b", buf_count, 1);
    chk("coll_data_b", out_data, 32'hC1);
    tick();
    drain("coll_drain");

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 600; i++) begin
      flush     = ($urandom_range(0, 39) == 0);
      out_ready = $urandom_range(0, 2) != 0;
      wr_en     = !flush && (cnt < 4) && ($urandom_range(0, 3) != 0);
      wr_data   = $urandom;
      tick();
    end
    flush = 1'b0;
    drain("rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
